// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the round-robin ALU arbiter.
//                Holds the ALU opcode encodings and the arbiter FSM states.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    // ALU opcodes (3-bit)
    localparam logic [2:0] OP_ADD = 3'b000;  // a + b
    localparam logic [2:0] OP_SUB = 3'b001;  // a + ~b + 1
    localparam logic [2:0] OP_NOT = 3'b010;  // ~a
    localparam logic [2:0] OP_AND = 3'b011;  // a & b
    localparam logic [2:0] OP_OR  = 3'b100;  // a | b
    localparam logic [2:0] OP_XOR = 3'b101;  // a ^ b
    localparam logic [2:0] OP_SLT = 3'b110;  // signed a < b
    localparam logic [2:0] OP_EQ  = 3'b111;  // a == b

    // Arbiter FSM states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_unit
//  Description : Registered WIDTH-bit ALU. Result/flags update only while en=1
//                and hold their value otherwise.
//  Ports       : clk, rst_n (async, active low), en, op[2:0], a, b
//                -> result, cout, ovf (ovf only with ALU_ARB_OVF_EN defined)
//  Config      : ALU_ARB_OVF_EN adds the signed-overflow flag output ovf.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
`ifdef ALU_ARB_OVF_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);

    // One extra bit so the carry/no-borrow falls out as bit WIDTH.
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] result_d;
    logic             cout_d;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        result_d = '0;
        cout_d   = 1'b0;
        case (op)
            OP_ADD: begin
                result_d = sum[WIDTH-1:0];
                cout_d   = sum[WIDTH];
            end
            OP_SUB: begin
                result_d = diff[WIDTH-1:0];
                cout_d   = diff[WIDTH];
            end
            OP_NOT: result_d = ~a;
            OP_AND: result_d = a & b;
            OP_OR:  result_d = a | b;
            OP_XOR: result_d = a ^ b;
            OP_SLT: result_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_EQ:  result_d = {{(WIDTH-1){1'b0}}, (a == b)};
            default: ;
        endcase
    end

`ifdef ALU_ARB_OVF_EN
    logic ovf_d;

    // Overflow: operands (with b inverted for sub) share a sign that the
    // result does not.
    always_comb begin
        ovf_d = 1'b0;
        case (op)
            OP_ADD: ovf_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
            OP_SUB: ovf_d = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (en) begin
            ovf <= ovf_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            cout   <= 1'b0;
        end else if (en) begin
            result <= result_d;
            cout   <= cout_d;
        end
    end

endmodule : alu_unit
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Shares one registered ALU between NREQ requesters using
//                round-robin arbitration. Flow per op: IDLE (grant + latch
//                operands) -> EXEC (ALU registers result) -> RESP (valid/ready
//                handshake) -> IDLE.
//  Ports       : clk, rst_n (async, active low)
//                req[NREQ], req_op[3*NREQ], req_a/req_b[WIDTH*NREQ] in
//                req_ack[NREQ] out (one-hot pulse in IDLE)
//                resp_valid out, resp_ready in, resp_id[IDW], resp_result[WIDTH],
//                resp_cout, resp_ovf (only with ALU_ARB_OVF_EN defined)
//  Config      : ALU_ARB_OVF_EN adds the signed-overflow output resp_ovf.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [3*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    output logic [NREQ-1:0]       req_ack,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [WIDTH-1:0]      resp_result,
`ifdef ALU_ARB_OVF_EN
    output logic                  resp_cout,
    output logic                  resp_ovf
`else
    output logic                  resp_cout
`endif
);

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;

    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic             latch_en;

    // Round-robin search: first asserted request starting at ptr, wrapping.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!grant_found && req[idx]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        req_ack    = '0;
        resp_valid = 1'b0;
        latch_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Gated by rst_n so no ack leaks out while reset is held.
                if (grant_found && rst_n) begin
                    req_ack[grant_idx] = 1'b1;
                    latch_en           = 1'b1;
                    state_d            = S_EXEC;
                end
            end
            S_EXEC: state_d = S_RESP;
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    // Next search starts just past the requester just served.
                    ptr_d   = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (latch_en) begin
                id_q <= grant_idx;
                op_q <= req_op[3*int'(grant_idx) +: 3];
                a_q  <= req_a[WIDTH*int'(grant_idx) +: WIDTH];
                b_q  <= req_b[WIDTH*int'(grant_idx) +: WIDTH];
            end
        end
    end

    assign resp_id = id_q;

    alu_unit #(
        .WIDTH (WIDTH)
    ) u_alu (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (state_q == S_EXEC),
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (resp_result),
`ifdef ALU_ARB_OVF_EN
        .cout   (resp_cout),
        .ovf    (resp_ovf)
`else
        .cout   (resp_cout)
`endif
    );

endmodule : alu_arbiter
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Self-checking bench for alu_arbiter. A transaction-level model
//                (pending-request table, pointer, busy/age counter, arithmetic
//                ALU reference) predicts ack, response timing and payload.
//                Overflow checks are compiled in with ALU_ARB_OVF_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [3*N-1:0]  req_op;
    logic [W*N-1:0]  req_a;
    logic [W*N-1:0]  req_b;
    logic [N-1:0]    req_ack;
    logic            resp_valid;
    logic            resp_ready;
    logic [IW-1:0]   resp_id;
    logic [W-1:0]    resp_result;
    logic            resp_cout;
`ifdef ALU_ARB_OVF_EN
    logic            resp_ovf;
`endif

    alu_arbiter #(.NREQ(N), .WIDTH(W), .IDW(IW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ack     (req_ack),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
`ifdef ALU_ARB_OVF_EN
        .resp_cout   (resp_cout),
        .resp_ovf    (resp_ovf)
`else
        .resp_cout   (resp_cout)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Requester-side table and model state
    bit         pend [N];
    logic [2:0] p_op [N];
    logic [3:0] p_a  [N];
    logic [3:0] p_b  [N];
    bit         rdy;
    int         m_ptr;
    bit         m_busy;
    int         m_age;
    int         m_id;
    logic [3:0] m_res;
    logic       m_cout;
    logic       m_ovf;
    int         served_q[$];   // DUT resp_id at each accepted response
    logic [3:0] last_res;
    logic       last_cout;
    logic       last_ovf;

    function automatic int sval(input logic [3:0] v);
        return (v >= 8) ? int'(v) - 16 : int'(v);
    endfunction

    // Returns {ovf, cout, result[3:0]} from plain arithmetic.
    function automatic logic [5:0] alu_ref(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        int ua, ub, sa, sb, s;
        logic [3:0] res;
        logic c, o;
        ua = int'(a); ub = int'(b); sa = sval(a); sb = sval(b);
        c = 1'b0; o = 1'b0; res = 4'd0;
        case (op)
            3'd0: begin s = ua + ub; res = 4'(s % 16); c = (s > 15); o = (sa + sb > 7) || (sa + sb < -8); end
            3'd1: begin res = 4'((ua - ub + 16) % 16); c = (ua >= ub); o = (sa - sb > 7) || (sa - sb < -8); end
            3'd2: res = 4'(15 - ua);
            3'd3: res = a & b;
            3'd4: res = a | b;
            3'd5: res = a ^ b;
            3'd6: res = (sa < sb) ? 4'd1 : 4'd0;
            default: res = (ua == ub) ? 4'd1 : 4'd0;
        endcase
        return {o, c, res};
    endfunction

    task automatic arm(input int i);
        pend[i] = 1'b1;
        p_op[i] = 3'($urandom_range(0, 7));
        p_a[i]  = 4'($urandom_range(0, 15));
        p_b[i]  = 4'($urandom_range(0, 15));
    endtask

    // One clock: drive at negedge, check outputs, advance the model.
    task automatic step();
        int w;
        logic [N-1:0] exp_ack;
        bit exp_valid;
        logic [5:0] r;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            req[i]           = pend[i];
            req_op[3*i +: 3] = p_op[i];
            req_a[W*i +: W]  = p_a[i];
            req_b[W*i +: W]  = p_b[i];
        end
        resp_ready = rdy;
        #1;
        w = -1;
        if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (w < 0 && pend[idx]) w = idx;
            end
        end
        exp_ack = '0;
        if (w >= 0) exp_ack[w] = 1'b1;
        checks++;
        if (req_ack !== exp_ack) begin
            errors++;
            $display("FAIL ack: got %b expected %b (t=%0t)", req_ack, exp_ack, $time);
        end
        exp_valid = m_busy && (m_age >= 2);
        checks++;
        if (resp_valid !== exp_valid) begin
            errors++;
            $display("FAIL resp_valid: got %b expected %b (t=%0t)", resp_valid, exp_valid, $time);
        end
        if (exp_valid) begin
            checks++;
            if (resp_id !== IW'(m_id) || resp_result !== m_res || resp_cout !== m_cout) begin
                errors++;
                $display("FAIL resp_payload: got id=%0d res=%h cout=%b expected id=%0d res=%h cout=%b",
                         resp_id, resp_result, resp_cout, m_id, m_res, m_cout);
            end
`ifdef ALU_ARB_OVF_EN
            checks++;
            if (resp_ovf !== m_ovf) begin
                errors++;
                $display("FAIL resp_ovf: got %b expected %b", resp_ovf, m_ovf);
            end
`endif
        end
        if (w >= 0) begin
            r       = alu_ref(p_op[w], p_a[w], p_b[w]);
            m_res   = r[3:0];
            m_cout  = r[4];
            m_ovf   = r[5];
            m_busy  = 1'b1;
            m_age   = 1;
            m_id    = w;
            pend[w] = 1'b0;
        end else if (exp_valid && rdy) begin
            served_q.push_back(int'(resp_id));
            last_res  = resp_result;
            last_cout = resp_cout;
`ifdef ALU_ARB_OVF_EN
            last_ovf  = resp_ovf;
`endif
            m_busy = 1'b0;
            m_ptr  = (m_id + 1) % N;
        end else if (m_busy) begin
            m_age++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (req_ack !== '0 || resp_valid !== 1'b0 || resp_id !== '0 || resp_result !== '0 || resp_cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got ack=%b valid=%b id=%0d res=%h cout=%b expected all 0",
                     req_ack, resp_valid, resp_id, resp_result, resp_cout);
        end
        m_busy = 1'b0;
        m_ptr  = 0;
        @(negedge clk);
        req   = '0;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        rdy = 1'b1;
        for (int t = 0; t < 10 && m_busy; t++) step();
        checks++;
        if (m_busy) begin
            errors++;
            $display("FAIL drain_timeout: got busy=1 expected idle");
        end
    endtask

    task automatic run_one(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        int n0;
        n0 = served_q.size();
        p_op[0] = op; p_a[0] = a; p_b[0] = b; pend[0] = 1'b1;
        rdy = 1'b1;
        for (int t = 0; t < 10 && served_q.size() == n0; t++) step();
        checks++;
        if (served_q.size() == n0) begin
            errors++;
            $display("FAIL run_one_timeout: got no response expected one");
        end
    endtask

    task automatic test_reset();
        req = '0; req_op = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin pend[i] = 0; p_op[i] = 0; p_a[i] = 0; p_b[i] = 0; end
        rdy = 1'b1;
        rst_n = 1'b1;
        do_reset();
    endtask

    task automatic test_single();
        served_q.delete();
        p_op[2] = 3'b000; p_a[2] = 4'd7; p_b[2] = 4'd9; pend[2] = 1'b1;
        for (int t = 0; t < 3; t++) step();
        checks++;
        if (served_q.size() != 1 || served_q[0] != 2 || last_res !== 4'd0 || last_cout !== 1'b1) begin
            errors++;
            $display("FAIL single: got n=%0d res=%h cout=%b expected id=2 res=0 cout=1",
                     served_q.size(), last_res, last_cout);
        end
    endtask

    task automatic test_round_robin();
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        do_reset();
        served_q.delete();
        rdy = 1'b1;
        for (int i = 0; i < N; i++) arm(i);
        for (int t = 0; t < 15; t++) begin
            step();
            for (int i = 0; i < N; i++) if (!pend[i]) arm(i);
        end
        checks++;
        if (served_q.size() != 5) begin
            errors++;
            $display("FAIL rr_count: got %0d expected 5", served_q.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (served_q[k] != exp_seq[k]) begin
                    errors++;
                    $display("FAIL rr_order[%0d]: got %0d expected %0d", k, served_q[k], exp_seq[k]);
                end
            end
        end
        for (int i = 0; i < N; i++) pend[i] = 0;
        drain();
    endtask

    task automatic test_compare_ops();
        run_one(3'b110, 4'b1000, 4'b0001);
        checks++;
        if (last_res !== 4'd1) begin errors++; $display("FAIL slt_neg: got %h expected 1", last_res); end
        run_one(3'b110, 4'b0001, 4'b1000);
        checks++;
        if (last_res !== 4'd0) begin errors++; $display("FAIL slt_pos: got %h expected 0", last_res); end
        run_one(3'b111, 4'd5, 4'd5);
        checks++;
        if (last_res !== 4'd1) begin errors++; $display("FAIL eq: got %h expected 1", last_res); end
        run_one(3'b001, 4'd5, 4'd3);
        checks++;
        if (last_res !== 4'd2 || last_cout !== 1'b1) begin
            errors++; $display("FAIL sub_noborrow: got res=%h cout=%b expected 2/1", last_res, last_cout);
        end
    endtask

    task automatic test_backpressure();
        arm(1);
        rdy = 1'b0;
        for (int t = 0; t < 8 && !(m_busy && m_age >= 2); t++) step();
        pend[0] = 1'b1; pend[3] = 1'b1;   // waiting requests must not be acked
        for (int t = 0; t < 5; t++) step();
        checks++;
        if (!(m_busy && resp_valid === 1'b1)) begin
            errors++; $display("FAIL backpressure_hold: got valid=%b expected 1", resp_valid);
        end
        pend[0] = 1'b0; pend[3] = 1'b0;
        drain();
    endtask

    task automatic test_reset_in_exec();
        int n0;
        arm(2);
        rdy = 1'b1;
        for (int t = 0; t < 5 && !m_busy; t++) step();   // ack edge -> DUT in EXEC
        pend[2] = 1'b1;                                   // keep req high during reset
        do_reset();
        pend[2] = 1'b0;
        n0 = served_q.size();
        for (int t = 0; t < 4; t++) step();
        checks++;
        if (served_q.size() != n0) begin
            errors++; $display("FAIL dropped_op: got %0d responses expected 0", served_q.size() - n0);
        end
        arm(0); arm(2);
        for (int t = 0; t < 3; t++) step();
        checks++;
        if (served_q.size() != n0 + 1 || served_q[n0] != 0) begin
            errors++; $display("FAIL post_reset_grant: expected id 0 served first");
        end
        pend[0] = 0; pend[2] = 0;
        drain();
    endtask

`ifdef ALU_ARB_OVF_EN
    task automatic test_overflow();
        run_one(3'b000, 4'b0111, 4'b0001);
        checks++;
        if (last_res !== 4'b1000 || last_ovf !== 1'b1 || last_cout !== 1'b0) begin
            errors++; $display("FAIL ovf_add: got res=%b ovf=%b cout=%b expected 1000/1/0", last_res, last_ovf, last_cout);
        end
        run_one(3'b001, 4'b1000, 4'b0001);
        checks++;
        if (last_res !== 4'b0111 || last_ovf !== 1'b1) begin
            errors++; $display("FAIL ovf_sub: got res=%b ovf=%b expected 0111/1", last_res, last_ovf);
        end
        run_one(3'b001, 4'd3, 4'd5);
        checks++;
        if (last_res !== 4'b1110 || last_cout !== 1'b0 || last_ovf !== 1'b0) begin
            errors++; $display("FAIL sub_borrow: got res=%b cout=%b ovf=%b expected 1110/0/0", last_res, last_cout, last_ovf);
        end
    endtask
`endif

    task automatic test_random();
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) arm(i);
                else if (pend[i] && $urandom_range(0, 15) == 0) pend[i] = 1'b0;  // withdraw before ack
            end
            rdy = ($urandom_range(0, 2) != 0);
            step();
        end
        for (int i = 0; i < N; i++) pend[i] = 0;
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_compare_ops();
        test_backpressure();
        test_reset_in_exec();
`ifdef ALU_ARB_OVF_EN
        test_overflow();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_alu_arbiter
`default_nettype wire
